// File: rtl/fetch_queue.sv
// Dual-issue fetch queue: circular buffer accepting instruction pairs and presenting head/head+1 to decode.
// Optional statistics counters (full_cycles, flush_count) are enabled by defining FETCHQ_STATS_EN.
module fetch_queue #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid_a,
    input  logic                     in_valid_b,
    input  logic [31:0]              in_pc_a,
    input  logic [31:0]              in_pc_b,
    input  logic [31:0]              in_instr_a,
    input  logic [31:0]              in_instr_b,
    output logic                     in_ready,
    input  logic                     stall,
    input  logic                     flush,
    output logic                     out_valid_a,
    output logic                     out_valid_b,
    output logic [31:0]              out_pc_a,
    output logic [31:0]              out_pc_b,
    output logic [31:0]              out_instr_a,
    output logic [31:0]              out_instr_b,
    output logic [$clog2(DEPTH):0]   count
`ifdef FETCHQ_STATS_EN
    ,
    output logic [31:0]              full_cycles,
    output logic [31:0]              flush_count
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] head_p1, tail_p1;

    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];

    logic       push_a, push_b;
    logic [1:0] n_push, n_pop;

    // Readiness and head visibility depend only on registered occupancy.
    always_comb begin
        head_p1     = head_q + PTR_W'(1);
        tail_p1     = tail_q + PTR_W'(1);
        in_ready    = (count_q <= CNT_W'(DEPTH - 2));
        out_valid_a = (count_q >= CNT_W'(1));
        out_valid_b = (count_q >= CNT_W'(2));
        out_pc_a    = out_valid_a ? pc_mem[head_q]     : 32'h0;
        out_instr_a = out_valid_a ? instr_mem[head_q]  : 32'h0;
        out_pc_b    = out_valid_b ? pc_mem[head_p1]    : 32'h0;
        out_instr_b = out_valid_b ? instr_mem[head_p1] : 32'h0;
        count       = count_q;
    end

    // Slot B without slot A is ignored; flush discards any same-cycle push and pop.
    always_comb begin
        push_a  = in_ready & ~flush & in_valid_a;
        push_b  = push_a & in_valid_b;
        n_push  = {1'b0, push_a} + {1'b0, push_b};
        n_pop   = (stall | flush) ? 2'd0 : ({1'b0, out_valid_a} + {1'b0, out_valid_b});
        head_d  = head_q + PTR_W'(n_pop);
        tail_d  = tail_q + PTR_W'(n_push);
        count_d = count_q + CNT_W'(n_push) - CNT_W'(n_pop);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push_a) begin
            pc_mem[tail_q]    <= in_pc_a;
            instr_mem[tail_q] <= in_instr_a;
        end
        if (push_b) begin
            pc_mem[tail_p1]    <= in_pc_b;
            instr_mem[tail_p1] <= in_instr_b;
        end
    end

`ifdef FETCHQ_STATS_EN
    logic [31:0] full_cycles_q, full_cycles_d;
    logic [31:0] flush_count_q, flush_count_d;

    // Saturating event counters, cleared only by reset.
    always_comb begin
        full_cycles_d = full_cycles_q;
        flush_count_d = flush_count_q;
        if (!in_ready && (full_cycles_q != 32'hFFFF_FFFF)) begin
            full_cycles_d = full_cycles_q + 32'd1;
        end
        if (flush && (flush_count_q != 32'hFFFF_FFFF)) begin
            flush_count_d = flush_count_q + 32'd1;
        end
        full_cycles = full_cycles_q;
        flush_count = flush_count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_cycles_q <= '0;
            flush_count_q <= '0;
        end else begin
            full_cycles_q <= full_cycles_d;
            flush_count_q <= flush_count_d;
        end
    end
`endif

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 8, queue entries; SHALL be a power of two and at least 4.
REQ-002 Port clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port in_valid_a / in_valid_b  input  1 each  fetch slot A / slot B carries an instruction.
REQ-005 Port in_pc_a / in_pc_b  input  32 each  PC of slot A / slot B.
REQ-006 Port in_instr_a / in_instr_b  input  32 each  instruction word of slot A / slot B.
REQ-007 Port in_ready  output  1  queue can accept a full pair this cycle.
REQ-008 Port stall  input  1  decode/hazard unit holds; no entries leave.
REQ-009 Port flush  input  1  branch redirect; discard all contents.
REQ-010 Port out_valid_a / out_valid_b  output  1 each  head / head+1 entry valid toward decode.
REQ-011 Port out_pc_a / out_pc_b, out_instr_a / out_instr_b  output  32 each  head / head+1 PC and instruction.
REQ-012 Port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-013 Queue SHALL be a circular buffer: head and tail pointers of $clog2(DEPTH) bits wrapping modulo DEPTH, plus an occupancy counter.
REQ-014 in_ready SHALL be 1 iff count <= DEPTH-2, computed from registered count only; no combinational path from stall, flush or in_valid_*.
REQ-015 Push: when in_ready=1, flush=0, in_valid_a=1, A SHALL be written at tail; if in_valid_b=1 also, B SHALL be written at tail+1; tail advances by 1 or 2.
REQ-016 in_valid_b=1 with in_valid_a=0 is illegal; the queue SHALL ignore slot B in that case.
REQ-017 Pushes with in_ready=0 SHALL be dropped; fetch holds its PC.
REQ-018 Outputs SHALL be first-word-fall-through: out_*_a shows entry[head], out_*_b shows entry[head+1] in the same cycle, zero added latency.
REQ-019 out_valid_a SHALL be (count>=1); out_valid_b SHALL be (count>=2); out_valid_b=1 never with out_valid_a=0.
REQ-020 Pop: when stall=0 and flush=0, head SHALL advance by out_valid_a+out_valid_b and those entries are consumed.
REQ-021 Simultaneous push and pop SHALL update count = count + pushed - popped in one cycle; with DEPTH>=4 and REQ-014 no overflow is possible.
REQ-022 Flush SHALL set head=tail=0 and count=0 next cycle, discarding any same-cycle push and pop; flush dominates stall.
REQ-023 out_pc_* and out_instr_* SHALL be 0 whenever the corresponding out_valid_* is 0.
REQ-024 Program order SHALL be preserved: A before B within a pair, pairs in push order, across pointer wrap.

Reset
REQ-025 On reset: head=0, tail=0, count=0, out_valid_a=out_valid_b=0, all out_pc/out_instr=0, in_ready=1, statistic counters 0.
REQ-026 Reset asserted mid-operation SHALL discard all contents at the next edge and take priority over flush, push and pop.
REQ-027 Entry storage contents need no reset.

Configuration
REQ-028 Macro FETCHQ_STATS_EN defined: add outputs full_cycles (32) counting cycles with in_ready=0, and flush_count (32) counting asserted flush cycles; both saturate at 0xFFFF_FFFF, cleared only by reset.
REQ-029 Macro FETCHQ_STATS_EN undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-030 Reset, push pair (0x0,0x00000013),(0x4,0x00100093), stall=0 -> next cycle out_valid_a=b=1, out_pc_a=0x0, out_pc_b=0x4, count=2; following cycle count=0.
REQ-031 stall=1, push 4 pairs with DEPTH=8 -> count 2,4,6,8; in_ready=0 at count=8; fifth push dropped; outputs still show PC 0x0/0x4.
REQ-032 count=3, stall=0, push one pair -> count stays 3 (push 2, pop 2), order preserved.
REQ-033 count=5, flush=1 with push and stall -> next cycle count=0, out_valid_a=0, in_ready=1; flush_count=1 when FETCHQ_STATS_EN defined.
REQ-034 Stream 20 pairs PC 0x0..0x9C with stall toggling every 3 cycles -> decode sees PCs strictly ascending by 4, none lost or duplicated, across multiple pointer wraps.
REQ-035 count=1, push A only (PC 0x40) with stall=0 -> pop 1, push 1, count=1, out_pc_a=0x40 next cycle.
